core_csr_bank: RTL and testbench



---
 rtl/core_csr_bank.sv | 217 +++++++++++++++++++++
 tb/tb_core_csr_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_csr_bank.sv
// Machine-mode CSR bank for the LETC core: combinational read port,
// committed write/set/clear port, trap/mret sequencing and 64-bit counters.
module core_csr_bank #(
    parameter int unsigned NUM_HPM     = 4,
    parameter logic [31:0] MHARTID     = 32'h0,
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [11:0]                               csr_sel,
    input  logic [1:0]                                csr_op,
    input  logic [31:0]                               csr_wdata,
    input  logic                                      csr_commit,
    output logic [31:0]                               csr_rdata,
    output logic                                      csr_illegal,
    input  logic                                      instret_inc,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]  hpm_event,
    input  logic                                      trap_req,
    input  logic [31:0]                               trap_cause,
    input  logic [31:0]                               trap_pc,
    input  logic [31:0]                               trap_tval,
    input  logic                                      mret_req,
    output logic [31:0]                               csr_mstatus,
    output logic [31:0]                               csr_satp,
    output logic [31:0]                               csr_mtvec,
    output logic [31:0]                               csr_mepc
);

    localparam int unsigned HPM_W        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] MISA         = 32'h4000_1101;
    localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    logic        mstatusMie_q, mstatusMie_d;
    logic        mstatusMpie_q, mstatusMpie_d;
    logic [1:0]  mstatusMpp_q, mstatusMpp_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] satp_q, satp_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] intEnable_q, intEnable_d;
    logic [31:0] countInhibit_q, countInhibit_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] hpm_q [HPM_W];
    logic [63:0] hpm_d [HPM_W];

    logic [31:0] mstatusVal;
    logic        csrImpl;
    logic [31:0] writeVal;
    logic        doWrite;

    assign mstatusVal  = {19'b0, mstatusMpp_q, 3'b0, mstatusMpie_q, 3'b0, mstatusMie_q, 3'b0};
    assign csr_mstatus = mstatusVal;
    assign csr_satp    = satp_q;
    assign csr_mtvec   = mtvec_q;
    assign csr_mepc    = mepc_q;

    // Address decode: pre-write read value and whether the address exists
    always_comb begin
        csrImpl   = 1'b1;
        csr_rdata = 32'h0;
        case (csr_sel)
            12'hF01, 12'h301: csr_rdata = MISA;
            12'hF11, 12'hF12, 12'hF13, 12'h344: csr_rdata = 32'h0;
            12'hF14: csr_rdata = MHARTID;
            12'h300: csr_rdata = mstatusVal;
            12'h304: csr_rdata = intEnable_q;
            12'h305: csr_rdata = mtvec_q;
            12'h320: csr_rdata = countInhibit_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h180: csr_rdata = satp_q;
            12'hB00, 12'hC00: csr_rdata = cycle_q[31:0];
            12'hB80, 12'hC80: csr_rdata = cycle_q[63:32];
            12'hB02, 12'hC02: csr_rdata = instret_q[31:0];
            12'hB82, 12'hC82: csr_rdata = instret_q[63:32];
            default: csrImpl = 1'b0;
        endcase
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_sel == 12'h323 + 12'(i)) begin
                csrImpl   = 1'b1;
                csr_rdata = 32'h0;
            end
            if (csr_sel == 12'hB03 + 12'(i) || csr_sel == 12'hC03 + 12'(i)) begin
                csrImpl   = 1'b1;
                csr_rdata = hpm_q[i][31:0];
            end
            if (csr_sel == 12'hB83 + 12'(i) || csr_sel == 12'hC83 + 12'(i)) begin
                csrImpl   = 1'b1;
                csr_rdata = hpm_q[i][63:32];
            end
        end
        csr_illegal = !csrImpl || (csr_op != 2'b00 && csr_sel[11:10] == 2'b11);
    end

    // Write/set/clear result and the gate that lets it land this edge
    always_comb begin
        case (csr_op)
            2'b01:   writeVal = csr_wdata;
            2'b10:   writeVal = csr_rdata | csr_wdata;
            2'b11:   writeVal = csr_rdata & ~csr_wdata;
            default: writeVal = csr_rdata;
        endcase
        doWrite = csr_commit && csr_op != 2'b00 && !csr_illegal && !trap_req && !mret_req;
    end

    // Next state: counter increments, software writes, then trap/mret sequencing
    always_comb begin
        mstatusMie_d   = mstatusMie_q;
        mstatusMpie_d  = mstatusMpie_q;
        mstatusMpp_d   = mstatusMpp_q;
        mtvec_d        = mtvec_q;
        satp_d         = satp_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mscratch_d     = mscratch_q;
        intEnable_d    = intEnable_q;
        countInhibit_d = countInhibit_q;
        cycle_d        = countInhibit_q[0] ? cycle_q : cycle_q + 64'd1;
        instret_d      = (instret_inc && !countInhibit_q[2]) ? instret_q + 64'd1 : instret_q;
        for (int i = 0; i < HPM_W; i++) begin
            hpm_d[i] = hpm_q[i];
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (hpm_event[i] && !countInhibit_q[3+i]) begin
                hpm_d[i] = hpm_q[i] + 64'd1;
            end
            if (doWrite && csr_sel == 12'hB03 + 12'(i)) begin
                hpm_d[i] = {hpm_q[i][63:32], writeVal};
            end
            if (doWrite && csr_sel == 12'hB83 + 12'(i)) begin
                hpm_d[i] = {writeVal, hpm_q[i][31:0]};
            end
        end
        if (doWrite) begin
            case (csr_sel)
                12'h300: begin
                    mstatusMie_d  = writeVal[3];
                    mstatusMpie_d = writeVal[7];
                    if (writeVal[12:11] == 2'b00 || writeVal[12:11] == 2'b11) begin
                        mstatusMpp_d = writeVal[12:11];
                    end
                end
                12'h304: intEnable_d    = writeVal & 32'h0000_0888;
                12'h305: mtvec_d        = writeVal & ~32'h2;
                12'h320: countInhibit_d = writeVal & INHIBIT_MASK;
                12'h340: mscratch_d     = writeVal;
                12'h341: mepc_d         = writeVal & ~32'h3;
                12'h342: mcause_d       = writeVal;
                12'h343: mtval_d        = writeVal;
                12'h180: satp_d         = writeVal;
                12'hB00: cycle_d        = {cycle_q[63:32], writeVal};
                12'hB80: cycle_d        = {writeVal, cycle_q[31:0]};
                12'hB02: instret_d      = {instret_q[63:32], writeVal};
                12'hB82: instret_d      = {writeVal, instret_q[31:0]};
                default: ;
            endcase
        end
        if (trap_req) begin
            mepc_d        = trap_pc & ~32'h3;
            mcause_d      = trap_cause;
            mtval_d       = trap_tval;
            mstatusMpie_d = mstatusMie_q;
            mstatusMie_d  = 1'b0;
            mstatusMpp_d  = 2'b11;
        end else if (mret_req) begin
            mstatusMie_d  = mstatusMpie_q;
            mstatusMpie_d = 1'b1;
            mstatusMpp_d  = 2'b00;
        end
    end

    // State registers with asynchronous reset to architectural reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatusMie_q   <= 1'b0;
            mstatusMpie_q  <= 1'b0;
            mstatusMpp_q   <= 2'b11;
            mtvec_q        <= RESET_MTVEC & ~32'h2;
            satp_q         <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mscratch_q     <= '0;
            intEnable_q    <= '0;
            countInhibit_q <= '0;
            cycle_q        <= '0;
            instret_q      <= '0;
            for (int i = 0; i < HPM_W; i++) begin
                hpm_q[i] <= '0;
            end
        end else begin
            mstatusMie_q   <= mstatusMie_d;
            mstatusMpie_q  <= mstatusMpie_d;
            mstatusMpp_q   <= mstatusMpp_d;
            mtvec_q        <= mtvec_d;
            satp_q         <= satp_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mscratch_q     <= mscratch_d;
            intEnable_q    <= intEnable_d;
            countInhibit_q <= countInhibit_d;
            cycle_q        <= cycle_d;
            instret_q      <= instret_d;
            for (int i = 0; i < HPM_W; i++) begin
                hpm_q[i] <= hpm_d[i];
            end
        end
    end

endmodule

// File: tb/tb_core_csr_bank.sv
// Directed bench for core_csr_bank with hand-computed expected values.
module tb_core_csr_bank;

    localparam int unsigned NUM_HPM     = 4;
    localparam logic [31:0] MHARTID     = 32'h0000_0005;
    localparam logic [31:0] RESET_MTVEC = 32'h8000_0042;

    logic         clk;
    logic         rst_n;
    logic [11:0]  csr_sel;
    logic [1:0]   csr_op;
    logic [31:0]  csr_wdata;
    logic         csr_commit;
    logic [31:0]  csr_rdata;
    logic         csr_illegal;
    logic         instret_inc;
    logic [NUM_HPM-1:0] hpm_event;
    logic         trap_req;
    logic [31:0]  trap_cause;
    logic [31:0]  trap_pc;
    logic [31:0]  trap_tval;
    logic         mret_req;
    logic [31:0]  csr_mstatus;
    logic [31:0]  csr_satp;
    logic [31:0]  csr_mtvec;
    logic [31:0]  csr_mepc;

    int testsRun = 0;
    int failures = 0;

    core_csr_bank #(
        .NUM_HPM(NUM_HPM),
        .MHARTID(MHARTID),
        .RESET_MTVEC(RESET_MTVEC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .csr_sel(csr_sel),
        .csr_op(csr_op),
        .csr_wdata(csr_wdata),
        .csr_commit(csr_commit),
        .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal),
        .instret_inc(instret_inc),
        .hpm_event(hpm_event),
        .trap_req(trap_req),
        .trap_cause(trap_cause),
        .trap_pc(trap_pc),
        .trap_tval(trap_tval),
        .mret_req(mret_req),
        .csr_mstatus(csr_mstatus),
        .csr_satp(csr_satp),
        .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Combinational read of one CSR with no operation pending
    task automatic checkCsr(input string tag, input logic [11:0] sel, input logic [31:0] expected);
        csr_sel = sel;
        csr_op  = 2'b00;
        #1;
        checkOutput(tag, csr_rdata, expected);
    endtask

    // Commit one CSR operation at the next rising edge, then return to idle
    task automatic applyStimulus(input logic [11:0] sel, input logic [1:0] op, input logic [31:0] wdata);
        csr_sel    = sel;
        csr_op     = op;
        csr_wdata  = wdata;
        csr_commit = 1'b1;
        @(posedge clk);
        #1;
        csr_commit = 1'b0;
        csr_op     = 2'b00;
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0; csr_sel = '0; csr_op = '0; csr_wdata = '0; csr_commit = 1'b0;
        instret_inc = 1'b0; hpm_event = '0; trap_req = 1'b0; trap_cause = '0;
        trap_pc = '0; trap_tval = '0; mret_req = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        checkCsr("misa F01", 12'hF01, 32'h4000_1101);
        checkCsr("mhartid", 12'hF14, MHARTID);
        checkCsr("mstatus reset", 12'h300, 32'h0000_1800);
        checkOutput("illegal on legal read", {31'b0, csr_illegal}, 32'h0);
        checkOutput("mtvec reset", csr_mtvec, 32'h8000_0040);
        checkOutput("satp reset", csr_satp, 32'h0);

        // minstret counts retire strobes
        instret_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1 instret_inc = 1'b0;
        checkCsr("minstret lo", 12'hB02, 32'h3);
        checkCsr("minstret hi shadow", 12'hC82, 32'h0);

        // mstatus WARL
        applyStimulus(12'h300, 2'b01, 32'hFFFF_FFFF);
        checkCsr("mstatus all ones", 12'h300, 32'h0000_1888);
        applyStimulus(12'h300, 2'b11, 32'h0000_0800);
        checkCsr("mstatus MPP=10 rejected", 12'h300, 32'h0000_1888);
        applyStimulus(12'h300, 2'b01, 32'h0000_1000);
        checkCsr("mstatus write MPP=10", 12'h300, 32'h0000_1800);

        // Other WARL fields
        applyStimulus(12'h305, 2'b01, 32'hFFFF_FFFF);
        checkOutput("mtvec bit1", csr_mtvec, 32'hFFFF_FFFD);
        applyStimulus(12'h341, 2'b01, 32'hFFFF_FFFF);
        checkOutput("mepc low bits", csr_mepc, 32'hFFFF_FFFC);
        applyStimulus(12'h304, 2'b01, 32'hFFFF_FFFF);
        checkCsr("mie mask", 12'h304, 32'h0000_0888);
        applyStimulus(12'h301, 2'b01, 32'h0);
        checkCsr("misa write ignored", 12'h301, 32'h4000_1101);
        applyStimulus(12'h180, 2'b01, 32'h8000_1234);
        checkOutput("satp write", csr_satp, 32'h8000_1234);

        // Illegal-access detection
        csr_sel = 12'hB07; csr_op = 2'b00; #1;
        checkOutput("B07 illegal", {31'b0, csr_illegal}, 32'h1);
        csr_sel = 12'h327; #1;
        checkOutput("327 illegal", {31'b0, csr_illegal}, 32'h1);
        csr_sel = 12'h326; #1;
        checkOutput("326 legal", {31'b0, csr_illegal}, 32'h0);
        csr_sel = 12'hC00; #1;
        checkOutput("C00 read legal", {31'b0, csr_illegal}, 32'h0);
        csr_op = 2'b01; #1;
        checkOutput("C00 write illegal", {31'b0, csr_illegal}, 32'h1);
        csr_sel = 12'hB03; #1;
        checkOutput("B03 write legal", {31'b0, csr_illegal}, 32'h0);
        csr_op = 2'b00;

        // HPM counters
        applyStimulus(12'hB03, 2'b01, 32'h0000_0055);
        checkCsr("hpm3 write", 12'hB03, 32'h0000_0055);
        hpm_event = 4'b0011;
        @(posedge clk); #1 hpm_event = '0;
        checkCsr("hpm3 inc", 12'hB03, 32'h0000_0056);
        checkCsr("hpm4 user shadow", 12'hC04, 32'h0000_0001);

        // mcycle carry and wrap
        applyStimulus(12'hB00, 2'b01, 32'hFFFF_FFFE);
        applyStimulus(12'hB80, 2'b01, 32'hFFFF_FFFF);
        checkCsr("mcycle lo after hi write", 12'hB00, 32'hFFFF_FFFE);
        checkCsr("mcycle hi written", 12'hB80, 32'hFFFF_FFFF);
        @(posedge clk); @(posedge clk); #1;
        checkCsr("mcycle wrap lo", 12'hB00, 32'h0);
        checkCsr("mcycle wrap hi", 12'hB80, 32'h0);
        applyStimulus(12'hB00, 2'b01, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        checkCsr("mcycle carry hi", 12'hB80, 32'h1);
        checkCsr("mcycle carry lo", 12'hB00, 32'h0);
        applyStimulus(12'h320, 2'b10, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkCsr("mcycle frozen lo", 12'hB00, 32'h1);
        checkCsr("mcycle frozen hi", 12'hC80, 32'h1);
        applyStimulus(12'hC00, 2'b01, 32'h1234);
        checkCsr("illegal commit no change", 12'hB00, 32'h1);
        applyStimulus(12'h320, 2'b01, 32'hFFFF_FFFF);
        checkCsr("mcountinhibit mask", 12'h320, 32'h0000_007D);
        hpm_event = 4'b0001;
        @(posedge clk); #1 hpm_event = '0;
        checkCsr("hpm3 inhibited", 12'hB03, 32'h0000_0056);

        // Trap beats mret and commit on the same edge
        applyStimulus(12'h300, 2'b01, 32'h0000_0008);
        checkOutput("mstatus pre-trap", csr_mstatus, 32'h0000_0008);
        applyStimulus(12'h340, 2'b01, 32'hAAAA_5555);
        csr_sel = 12'h340; csr_op = 2'b01; csr_wdata = 32'h1234_5678; csr_commit = 1'b1;
        trap_req = 1'b1; mret_req = 1'b1;
        trap_pc = 32'h0000_1003; trap_cause = 32'h2; trap_tval = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        trap_req = 1'b0; mret_req = 1'b0; csr_commit = 1'b0; csr_op = 2'b00;
        checkOutput("trap mepc", csr_mepc, 32'h0000_1000);
        checkOutput("trap mstatus", csr_mstatus, 32'h0000_1880);
        checkCsr("trap mcause", 12'h342, 32'h2);
        checkCsr("trap mtval", 12'h343, 32'hDEAD_BEEF);
        checkCsr("mscratch unchanged", 12'h340, 32'hAAAA_5555);

        // mret, with a competing commit that must be dropped
        csr_sel = 12'h340; csr_op = 2'b01; csr_wdata = 32'h0; csr_commit = 1'b1;
        mret_req = 1'b1;
        @(posedge clk); #1;
        mret_req = 1'b0; csr_commit = 1'b0; csr_op = 2'b00;
        checkOutput("mret mstatus", csr_mstatus, 32'h0000_0088);
        checkCsr("mret drops commit", 12'h340, 32'hAAAA_5555);
        applyStimulus(12'h300, 2'b11, 32'h0000_0080);
        checkOutput("clear MPIE", csr_mstatus, 32'h0000_0008);

        // Asynchronous reset mid-operation
        csr_sel = 12'h340; csr_op = 2'b01; csr_wdata = 32'h5555_0000; csr_commit = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset mstatus", csr_mstatus, 32'h0000_1800);
        checkOutput("async reset mepc", csr_mepc, 32'h0);
        @(posedge clk); #1;
        csr_commit = 1'b0; csr_op = 2'b00;
        rst_n = 1'b1;
        checkCsr("reset mscratch", 12'h340, 32'h0);
        checkCsr("reset mcountinhibit", 12'h320, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
